// File: rtl/softmax_norm_ctrl_pkg.sv
// Shared types and float32 helpers for the softmax normalisation sequencer.
// The float cores handle normal numbers only: denormal inputs flush to zero, rounding is nearest-even.
package softmax_norm_ctrl_pkg;

    localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

    typedef enum logic [2:0] {
        StIdle,
        StAccum,
        StRecip,
        StScale,
        StDone
    } state_e;

    function automatic logic is_zero_or_denorm(input logic [31:0] w);
        return w[30:23] == 8'd0;
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y;
        logic [26:0] mx, my, mask;
        logic [27:0] s;
        logic [7:0]  d;
        logic [24:0] r;
        logic        up;
        int          e;
        if (is_zero_or_denorm(a)) return is_zero_or_denorm(b) ? FP_ZERO : b;
        if (is_zero_or_denorm(b)) return a;
        if (a[30:0] >= b[30:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        d  = x[30:23] - y[30:23];
        mx = {1'b1, x[22:0], 3'b000};
        my = {1'b1, y[22:0], 3'b000};
        // Low three bits are guard/round/sticky for the aligned smaller operand.
        if (d > 8'd26) begin
            my = 27'd1;
        end else begin
            mask = (27'd1 << d) - 27'd1;
            my   = (my >> d) | {26'd0, |(my & mask)};
        end
        s = (x[31] == y[31]) ? {1'b0, mx} + {1'b0, my} : {1'b0, mx} - {1'b0, my};
        if (s == 28'd0) return FP_ZERO;
        e = int'(x[30:23]);
        if (s[27]) begin
            s = {1'b0, s[27:2], s[1] | s[0]};
            e++;
        end else begin
            for (int i = 0; i < 26; i++) begin
                if (!s[26]) begin
                    s = s << 1;
                    e--;
                end
            end
        end
        up = s[2] & (s[1] | s[0] | s[3]);
        r  = {1'b0, s[26:3]} + {24'd0, up};
        if (r[24]) begin
            r = r >> 1;
            e++;
        end
        if (e <= 0) return {x[31], 31'd0};
        if (e >= 255) return {x[31], 8'hFF, 23'd0};
        return {x[31], e[7:0], r[22:0]};
    endfunction

    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [23:0] m;
        logic [24:0] r;
        logic        rnd, stk, sgn;
        int          e;
        sgn = a[31] ^ b[31];
        if (is_zero_or_denorm(a) || is_zero_or_denorm(b)) return {sgn, 31'd0};
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m   = p[47:24];
            rnd = p[23];
            stk = |p[22:0];
            e++;
        end else begin
            m   = p[46:23];
            rnd = p[22];
            stk = |p[21:0];
        end
        r = {1'b0, m} + {24'd0, rnd & (stk | m[0])};
        if (r[24]) begin
            r = r >> 1;
            e++;
        end
        if (e <= 0) return {sgn, 31'd0};
        if (e >= 255) return {sgn, 8'hFF, 23'd0};
        return {sgn, e[7:0], r[22:0]};
    endfunction

endpackage

// File: rtl/softmax_norm_ctrl_if.sv
// Valid/ready stream carrying one float32 word per transfer.
interface softmax_norm_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;

    modport master (output data, output valid, input ready);
    modport slave (input data, input valid, output ready);
endinterface

// File: rtl/softmax_norm_ctrl_vec_buf.sv
// Register file holding one softmax vector; synchronous write, asynchronous read.
module softmax_norm_ctrl_vec_buf #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 10,
    parameter int unsigned ADDR_W     = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/softmax_norm_ctrl.sv
// SoftMax normalisation sequencer: accumulate CLASSES exp values, fetch 1/sum from the shared
// reciprocal unit, then stream each stored value scaled by that reciprocal.
module softmax_norm_ctrl
    import softmax_norm_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned CLASSES     = 10,
    parameter int unsigned REC_TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    softmax_norm_ctrl_if.slave        in_if,
    output logic [DATA_WIDTH-1:0]     rec_number,
    output logic                      rec_enable,
    input  logic [DATA_WIDTH-1:0]     rec_result,
    input  logic                      rec_ack,
    softmax_norm_ctrl_if.master       out_if,
    output logic                      done,
    output logic                      err
);

    localparam int unsigned IdxW  = $clog2(CLASSES);
    localparam int unsigned TcntW = $clog2(REC_TIMEOUT + 1);
    localparam logic [IdxW-1:0]  LastIdx = IdxW'(CLASSES - 1);
    localparam logic [TcntW-1:0] TcntMax = TcntW'(REC_TIMEOUT);

    state_e                state_q;
    logic [IdxW-1:0]       idx_q, idx_next, rd_idx;
    logic [TcntW-1:0]      tcnt_q, tcnt_inc;
    logic [DATA_WIDTH-1:0] sum_q, inv_q, sum_add, rd_data, product;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_valid_q;
    logic                  in_accept, out_accept;

    assign in_if.ready = ~reset & (state_q == StIdle || state_q == StAccum);
    assign in_accept   = in_if.valid & in_if.ready;
    assign out_accept  = out_valid_q & out_if.ready;
    assign out_if.data  = out_data_q;
    assign out_if.valid = out_valid_q;

    always_comb begin
        idx_next = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
        tcnt_inc = tcnt_q + 1'b1;
        // Look ahead one entry on an accept so a fresh product is ready every cycle.
        rd_idx   = (state_q == StScale && out_accept) ? idx_next : idx_q;
        sum_add  = fp_add(sum_q, in_if.data);
        product  = fp_mul(rd_data, inv_q);
    end

    softmax_norm_ctrl_vec_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (CLASSES),
        .ADDR_W     (IdxW)
    ) u_buf (
        .clk   (clk),
        .we    (in_accept),
        .waddr (idx_q),
        .wdata (in_if.data),
        .raddr (rd_idx),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            tcnt_q      <= '0;
            sum_q       <= FP_ZERO;
            inv_q       <= FP_ZERO;
            rec_number  <= '0;
            rec_enable  <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_accept) begin
                        sum_q   <= in_if.data;
                        idx_q   <= IdxW'(1);
                        err     <= 1'b0;
                        state_q <= StAccum;
                    end
                end
                StAccum: begin
                    if (in_accept) begin
                        sum_q <= sum_add;
                        if (idx_q == LastIdx) begin
                            idx_q <= '0;
                            if (is_zero_or_denorm(sum_add)) begin
                                err     <= 1'b1;
                                inv_q   <= FP_ZERO;
                                state_q <= StScale;
                            end else begin
                                rec_number <= sum_add;
                                tcnt_q     <= '0;
                                state_q    <= StRecip;
                            end
                        end else begin
                            idx_q <= idx_next;
                        end
                    end
                end
                StRecip: begin
                    // First cycle keeps enable low so the unit reloads its seed.
                    if (!rec_enable) begin
                        rec_enable <= 1'b1;
                    end else begin
                        tcnt_q <= tcnt_inc;
                        if (rec_ack || tcnt_inc == TcntMax) begin
                            inv_q      <= rec_result;
                            err        <= err | ~rec_ack;
                            rec_enable <= 1'b0;
                            state_q    <= StScale;
                        end
                    end
                end
                StScale: begin
                    if (!out_valid_q) begin
                        out_data_q  <= product;
                        out_valid_q <= 1'b1;
                    end else if (out_if.ready) begin
                        if (idx_q == LastIdx) begin
                            idx_q       <= '0;
                            out_valid_q <= 1'b0;
                            done        <= 1'b1;
                            state_q     <= StDone;
                        end else begin
                            idx_q      <= idx_next;
                            out_data_q <= product;
                        end
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
